// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, key code
// type, the "no key" marker used for frame results, the debounce FSM states
// and small row-vector helpers.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [3:0] key_code_t;

  // Frame result: bit 4 set means "no usable key" (nothing pressed or ghosting),
  // otherwise bits 3:0 carry row*4+col.
  typedef logic [4:0] key_cand_t;
  localparam key_cand_t KEY_NONE = 5'b1_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Number of active rows in one column sample (0..4).
  function automatic logic [2:0] count_rows(input logic [NUM_ROWS-1:0] rows);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      n = n + {2'b00, rows[i]};
    end
    return n;
  endfunction

  // Index of the lowest active row; only meaningful when exactly one row is set.
  function automatic logic [1:0] first_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (rows[i]) begin
        r = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous, active-low inputs. Resets to all
// ones so that a reset never looks like a pressed key.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two-stage capture of the raw pins into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b1}};
      q      <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d_async;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scan controller: walks an active-low column strobe,
// samples synchronized rows at the end of each column dwell, reduces each
// 4-column frame to a single-key candidate, debounces press and release over
// whole frames and hands accepted codes to a valid/ready holding register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 100
) (
  input  logic            clk,
  input  logic            rst,
  output logic [3:0]      col_n,
  input  logic [3:0]      row_n_async,
  output key_code_t       key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overrun
);

  localparam int DWELL_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST   = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ZERO   = DWELL_W'(0);
  localparam logic [DWELL_W-1:0] DWELL_ONE    = DWELL_W'(1);
  localparam logic [DEB_W-1:0]   DEB_TARGET   = DEB_W'(DEBOUNCE_FRAMES);
  localparam logic [DEB_W-1:0]   DEB_ZERO     = DEB_W'(0);
  localparam logic [DEB_W-1:0]   DEB_ONE      = DEB_W'(1);
  localparam bit                 SINGLE_FRAME = (DEBOUNCE_FRAMES == 1);

  // Elaboration-time guard on the parameter ranges the scanner relies on.
  if (SCAN_CYCLES < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: parameter out of supported range");
  end

  // ---------------------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] rows_sync_s;

  keypad_sync #(
    .WIDTH (NUM_ROWS)
  ) u_row_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (row_n_async),
    .q       (rows_sync_s)
  );

  // ---------------------------------------------------------------------------
  // Column scan and frame accumulation
  // ---------------------------------------------------------------------------
  logic [DWELL_W-1:0] dwell_r;
  logic [1:0]         col_idx_r;
  logic [1:0]         acc_cnt_r;   // keys seen so far in this frame, saturates at 2
  key_code_t          acc_code_r;  // code of the single key seen so far

  logic [3:0]  pressed_s;
  logic [2:0]  col_hits_s;
  key_code_t   col_code_s;
  logic        sample_s;
  logic        frame_end_s;
  logic [1:0]  merged_cnt_s;
  key_code_t   merged_code_s;
  key_cand_t   frame_res_s;

  // Column sample decode and merge with earlier columns into the frame result.
  always_comb begin
    pressed_s   = ~rows_sync_s;
    col_hits_s  = count_rows(pressed_s);
    col_code_s  = {first_row(pressed_s), col_idx_r};
    sample_s    = (dwell_r == DWELL_LAST);
    frame_end_s = sample_s && (col_idx_r == 2'd3);

    if (col_hits_s >= 3'd2) begin
      merged_cnt_s = 2'd2;
    end else if ((acc_cnt_r + col_hits_s[1:0]) >= 2'd2) begin
      merged_cnt_s = 2'd2;
    end else begin
      merged_cnt_s = acc_cnt_r + col_hits_s[1:0];
    end

    if (col_hits_s == 3'd1) begin
      merged_code_s = col_code_s;
    end else begin
      merged_code_s = acc_code_r;
    end

    if (merged_cnt_s == 2'd1) begin
      frame_res_s = {1'b0, merged_code_s};
    end else begin
      frame_res_s = KEY_NONE;
    end
  end

  // Dwell counter and one-hot active-low column strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_r   <= DWELL_ZERO;
      col_idx_r <= 2'd0;
      col_n     <= 4'b1110;
    end else if (sample_s) begin
      dwell_r   <= DWELL_ZERO;
      col_idx_r <= col_idx_r + 2'd1;
      col_n     <= ~(4'b0001 << (col_idx_r + 2'd1));
    end else begin
      dwell_r   <= dwell_r + DWELL_ONE;
    end
  end

  // Per-frame key accumulator, cleared as each frame is handed to the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (frame_end_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (sample_s) begin
      acc_cnt_r  <= merged_cnt_s;
      acc_code_r <= merged_code_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  scan_state_t      state_r;
  logic [DEB_W-1:0] deb_cnt_r;
  key_code_t        held_code_r;

  logic [DEB_W-1:0] cnt_inc_s;
  logic             deb_done_s;
  logic             same_s;
  logic             rep_hit_s;
  logic             emit_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int               REP_W      = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_FRAMES);
  localparam logic [REP_W-1:0] REP_ZERO   = REP_W'(0);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

  logic [REP_W-1:0] rep_cnt_r;
  logic [REP_W-1:0] rep_inc_s;

  // Saturating repeat increment and the frame that triggers a re-emission.
  always_comb begin
    if (rep_cnt_r >= REP_TARGET) begin
      rep_inc_s = rep_cnt_r;
    end else begin
      rep_inc_s = rep_cnt_r + REP_ONE;
    end
    rep_hit_s = frame_end_s && (state_r == PRESSED) && same_s && (rep_inc_s >= REP_TARGET);
  end

  // Repeat counter: counts held-code frames in PRESSED, idle at zero elsewhere
  // so it is always clear on entry to PRESSED.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_r <= REP_ZERO;
    end else if (frame_end_s) begin
      if (state_r != PRESSED) begin
        rep_cnt_r <= REP_ZERO;
      end else if (same_s) begin
        rep_cnt_r <= rep_hit_s ? REP_ZERO : rep_inc_s;
      end
    end
  end
`else
  // Without auto-repeat only the debounce completion emits.
  always_comb begin
    rep_hit_s = 1'b0;
  end
`endif

  // Frame-end emit decision, shared by the FSM and the holding register.
  always_comb begin
    if (deb_cnt_r >= DEB_TARGET) begin
      cnt_inc_s = deb_cnt_r;
    end else begin
      cnt_inc_s = deb_cnt_r + DEB_ONE;
    end
    deb_done_s = (cnt_inc_s >= DEB_TARGET);
    same_s     = (frame_res_s == {1'b0, held_code_r});
    emit_s     = 1'b0;
    if (frame_end_s) begin
      case (state_r)
        IDLE:     emit_s = (frame_res_s != KEY_NONE) && SINGLE_FRAME;
        DEBOUNCE: emit_s = same_s && deb_done_s;
        PRESSED:  emit_s = rep_hit_s;
        RELEASE:  emit_s = 1'b0;
        default:  emit_s = 1'b0;
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  // Press/release debounce state machine, evaluated once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      deb_cnt_r   <= DEB_ZERO;
      held_code_r <= 4'd0;
      key_held    <= 1'b0;
    end else if (frame_end_s) begin
      case (state_r)
        IDLE: begin
          if (frame_res_s != KEY_NONE) begin
            held_code_r <= frame_res_s[3:0];
            if (SINGLE_FRAME) begin
              state_r   <= PRESSED;
              deb_cnt_r <= DEB_ZERO;
              key_held  <= 1'b1;
            end else begin
              state_r   <= DEBOUNCE;
              deb_cnt_r <= DEB_ONE;
            end
          end
        end
        DEBOUNCE: begin
          if (!same_s) begin
            state_r   <= IDLE;
            deb_cnt_r <= DEB_ZERO;
          end else if (deb_done_s) begin
            state_r   <= PRESSED;
            deb_cnt_r <= DEB_ZERO;
            key_held  <= 1'b1;
          end else begin
            deb_cnt_r <= cnt_inc_s;
          end
        end
        PRESSED: begin
          if (!same_s) begin
            if (SINGLE_FRAME && (frame_res_s == KEY_NONE)) begin
              state_r   <= IDLE;
              deb_cnt_r <= DEB_ZERO;
              key_held  <= 1'b0;
            end else begin
              state_r   <= RELEASE;
              deb_cnt_r <= DEB_ONE;
            end
          end
        end
        RELEASE: begin
          if (same_s) begin
            state_r   <= PRESSED;
            deb_cnt_r <= DEB_ZERO;
          end else if (frame_res_s == KEY_NONE) begin
            if (deb_done_s) begin
              state_r   <= IDLE;
              deb_cnt_r <= DEB_ZERO;
              key_held  <= 1'b0;
            end else begin
              deb_cnt_r <= cnt_inc_s;
            end
          end else begin
            // A different single key restarts the release count.
            deb_cnt_r <= DEB_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          deb_cnt_r <= DEB_ZERO;
          key_held  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Valid/ready holding register
  // ---------------------------------------------------------------------------

  // Load on emit when empty or being drained; drop and flag when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= emit_s && key_valid && !key_ready;
      if (emit_s && (!key_valid || key_ready)) begin
        key_code  <= frame_res_s[3:0];
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
